// File: rtl/fmv_pkg.sv
// Shared types and helpers for the FMV pixel output stage: pixel type, line
// configuration payload, output state encoding and the crop width clamp.
package fmv_pkg;

  localparam int unsigned FMV_PIX_W = 24;
  localparam int unsigned FMV_CNT_W = 10;

  typedef logic [FMV_PIX_W-1:0] rgb888_t;
  typedef logic [FMV_CNT_W-1:0] fmv_cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    ACTIVE,
    DRAIN
  } fmv_out_state_e;

  // Per-line configuration captured at line_start
  typedef struct packed {
    fmv_cnt_t src_width;
    fmv_cnt_t crop_x;
    fmv_cnt_t eff_w;
  } fmv_line_cfg_t;

  localparam rgb888_t kFmvBlack = '0;

  // Pixels actually emitted: requested width clamped to what the crop leaves
  function automatic fmv_cnt_t fmv_eff_width(fmv_cnt_t src_w, fmv_cnt_t crop,
                                             fmv_cnt_t out_w);
    fmv_cnt_t crop_c;
    fmv_cnt_t avail;
    crop_c = (crop < src_w) ? crop : src_w;
    avail  = src_w - crop_c;
    return (out_w < avail) ? out_w : avail;
  endfunction

endpackage

// File: rtl/fmv_pixel_output_if.sv
// Decoder write channel and mixer pixel channel of the FMV pixel output stage.
interface fmv_pixel_output_if
  import fmv_pkg::*;
#(
  parameter int unsigned PIX_W = FMV_PIX_W
);

  logic             wr_valid;
  logic [PIX_W-1:0] wr_data;
  logic             wr_ready;
  logic [PIX_W-1:0] pix_out;
  logic             pix_valid;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready,
    input  pix_out,
    input  pix_valid
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready,
    output pix_out,
    output pix_valid
  );

endinterface

// File: rtl/fmv_pixel_fifo.sv
// Show-ahead synchronous pixel FIFO with registered full/empty flags and an
// occupancy count; reset flushes the contents by clearing the pointers.
module fmv_pixel_fifo
  import fmv_pkg::*;
#(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned W     = FMV_PIX_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/fmv_pixel_output.sv
// FMV pixel output: buffers decoded pixels, applies the horizontal crop and
// emits one pixel per newpixel strobe. FMV_UNDERFLOW_REPEAT_EN repeats the last
// pixel on underflow instead of emitting black.
module fmv_pixel_output
  import fmv_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 512,
  parameter int unsigned PIX_W      = FMV_PIX_W
) (
  input  logic                 clk30,
  input  logic                 reset,
  input  logic                 newpixel,
  input  logic                 line_start,
  input  logic [FMV_CNT_W-1:0] src_width,
  input  logic [FMV_CNT_W-1:0] crop_x,
  input  logic [FMV_CNT_W-1:0] out_width,
  fmv_pixel_output_if.slave    px,
  output logic                 underflow
);

  fmv_out_state_e   state_q, state_d;
  fmv_line_cfg_t    cfg_q, cfg_d;
  fmv_cnt_t         src_cnt_q, src_cnt_d;
  fmv_cnt_t         out_cnt_q, out_cnt_d;
  logic [PIX_W-1:0] pix_out_q, pix_out_d;
  logic             pix_valid_q, pix_valid_d;
  logic             underflow_q, underflow_d;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [PIX_W-1:0] fifo_head;

  assign fifo_push = px.wr_valid && !fifo_full;

  fmv_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PIX_W)
  ) u_fifo (
    .clk     (clk30),
    .rst     (reset),
    .push    (fifo_push),
    .wr_data (px.wr_data),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Line sequencing: line_start always restarts, even over a pending strobe
  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    src_cnt_d   = src_cnt_q;
    out_cnt_d   = out_cnt_q;
    pix_out_d   = pix_out_q;
    pix_valid_d = 1'b0;
    underflow_d = underflow_q;
    fifo_pop    = 1'b0;

    if (line_start) begin
      state_d         = SKIP;
      cfg_d.src_width = src_width;
      cfg_d.crop_x    = crop_x;
      cfg_d.eff_w     = fmv_eff_width(src_width, crop_x, out_width);
      src_cnt_d       = '0;
      out_cnt_d       = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end

        SKIP: begin
          if (cfg_q.eff_w == '0) begin
            state_d = DRAIN;
          end else if (src_cnt_q == cfg_q.crop_x) begin
            state_d = ACTIVE;
          end else if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            src_cnt_d = src_cnt_q + FMV_CNT_W'(1);
          end
        end

        ACTIVE: begin
          if (newpixel) begin
            pix_valid_d = 1'b1;
            out_cnt_d   = out_cnt_q + FMV_CNT_W'(1);
            if (!fifo_empty) begin
              fifo_pop  = 1'b1;
              pix_out_d = fifo_head;
              src_cnt_d = src_cnt_q + FMV_CNT_W'(1);
            end else begin
              underflow_d = 1'b1;
`ifdef FMV_UNDERFLOW_REPEAT_EN
              pix_out_d   = pix_out_q;
`else
              pix_out_d   = PIX_W'(kFmvBlack);
`endif
            end
            if (out_cnt_d == cfg_q.eff_w) begin
              state_d = DRAIN;
            end
          end
        end

        DRAIN: begin
          if (src_cnt_q >= cfg_q.src_width) begin
            state_d = IDLE;
          end else if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            src_cnt_d = src_cnt_q + FMV_CNT_W'(1);
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk30) begin
    if (reset) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      src_cnt_q   <= '0;
      out_cnt_q   <= '0;
      pix_out_q   <= '0;
      pix_valid_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      src_cnt_q   <= src_cnt_d;
      out_cnt_q   <= out_cnt_d;
      pix_out_q   <= pix_out_d;
      pix_valid_q <= pix_valid_d;
      underflow_q <= underflow_d;
    end
  end

  assign px.wr_ready  = !fifo_full;
  assign px.pix_out   = pix_out_q;
  assign px.pix_valid = pix_valid_q;
  assign underflow    = underflow_q;

endmodule
